line_memory: RTL and testbench

- Backing data memory directly downstream of the data cache.
- Consumes the cache's line-level request bus (enable, write, 32-bit address, 256-bit line) and returns a 256-bit line with a one-cycle ack pulse after a fixed latency.
- Models main-memory access delay so that cache stall behaviour is exercised.
- Holds one outstanding request at a time.

---
 rtl/mem_pkg.sv | 17 +
 rtl/line_array.sv | 28 ++
 rtl/line_memory.sv | 111 +++++++++++
 tb/tb_line_memory.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and FSM state type for the line memory
package mem_pkg;

    localparam int OFFSET_BITS = 5;
    localparam int DEF_LINE_W  = 256;
    localparam int DEF_DEPTH   = 512;
    localparam int DEF_LATENCY = 10;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_e;

endpackage

// File: rtl/line_array.sv
// rtl/line_array.sv - DEPTH x LINE_W line storage, synchronous write, combinational read
module line_array
    import mem_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    // Contents are deliberately not reset; the bench preloads them hierarchically.
    logic [LINE_W-1:0] lines [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            lines[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = lines[raddr_i];

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - fixed-latency line-level backing memory behind the data cache
module line_memory
    import mem_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [LINE_W-1:0] rd_line;
    logic              array_we;
    logic              unused_addr;

    // Offset bits and the bits above the line index are dropped, so addresses wrap.
    assign unused_addr = ^{addr_i[31:IDX_W+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[IDX_W+OFFSET_BITS-1:OFFSET_BITS];
                    wdata_d = data_i;
                    wr_d    = write_i;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    if (!wr_q) begin
                        rdata_d = rd_line;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = RECOVER;
            end
            RECOVER: begin
                // A requester still holding enable from the finished request must not restart it.
                if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    assign array_we = (state_q == ACK) && wr_q;
    assign ack_o    = (state_q == ACK);
    assign data_o   = rdata_q;

    line_array #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) memory (
        .clk_i   (clk_i),
        .we_i    (array_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (rd_line)
    );

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - directed self-checking bench for line_memory
module tb_line_memory;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_WR = {4{64'h1234_5678_9ABC_DEF0}};
    localparam logic [255:0] PAT_L4 = {32{8'h44}};
    localparam logic [255:0] PAT_L5 = {32{8'h55}};
    localparam logic [255:0] PAT_EE = {32{8'hEE}};
    localparam logic [255:0] PAT_JK = {32{8'h3C}};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         en;
    logic         en1;
    logic         wr;
    logic [255:0] dout;
    logic [255:0] dout1;
    logic         ack;
    logic         ack1;

    int checks = 0;
    int errors = 0;
    logic seen;

    always #5 clk = ~clk;

    line_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(10)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (en),
        .write_i  (wr),
        .data_o   (dout),
        .ack_o    (ack)
    );

    line_memory #(.LINE_W(256), .DEPTH(512), .LATENCY(1)) dut1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (addr),
        .data_i   (wdata),
        .enable_i (en1),
        .write_i  (wr),
        .data_o   (dout1),
        .ack_o    (ack1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the LATENCY=10 instance and check ack timing, data and no re-trigger.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [255:0] d,
                           input logic w, input logic [255:0] exp_data);
        addr = a; wdata = d; wr = w; en = 1'b1;
        tick();
        seen = ack;
        repeat (9) begin
            tick();
            seen |= ack;
        end
        chk({tag, "_early_ack"}, 256'(seen), 256'(1'b0));
        tick();
        chk({tag, "_ack"}, 256'(ack), 256'(1'b1));
        chk({tag, "_data"}, dout, exp_data);
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen |= ack;
        end
        chk({tag, "_no_dup_ack"}, 256'(seen), 256'(1'b0));
        en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; en = 1'b0; en1 = 1'b0; wr = 1'b0;
        dut.memory.lines[3]  = PAT_A5;
        dut.memory.lines[4]  = PAT_L4;
        dut.memory.lines[5]  = PAT_L5;
        dut1.memory.lines[3] = PAT_A5;
        tick();
        tick();
        chk("reset_ack", 256'(ack), 256'(1'b0));
        chk("reset_data", dout, 256'(0));
        rst = 1'b0;

        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= ack;
        end
        chk("idle_ack", 256'(seen), 256'(1'b0));
        chk("idle_data", dout, 256'(0));

        run_req("rd_line3", 32'h0000_0060, PAT_JK, 1'b0, PAT_A5);
        run_req("wr_0x400", 32'h0000_0400, PAT_WR, 1'b1, PAT_A5);
        run_req("rd_0x400", 32'h0000_0400, PAT_JK, 1'b0, PAT_WR);

        // Inputs changed mid-WAIT must be ignored.
        addr = 32'h0000_0060; wr = 1'b0; en = 1'b1;
        tick();
        repeat (3) tick();
        addr = 32'h0000_0080; wr = 1'b1; wdata = PAT_JK;
        repeat (6) tick();
        chk("chg_early_ack", 256'(ack), 256'(1'b0));
        tick();
        chk("chg_ack", 256'(ack), 256'(1'b1));
        chk("chg_data", dout, PAT_A5);
        en = 1'b0;
        tick();
        tick();
        run_req("rd_line4", 32'h0000_0080, PAT_JK, 1'b0, PAT_L4);

        run_req("wrap", 32'h0000_4060, PAT_JK, 1'b0, PAT_A5);

        // Reset four cycles into a write to line 5.
        addr = 32'h0000_00A0; wdata = PAT_EE; wr = 1'b1; en = 1'b1;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ack", 256'(ack), 256'(1'b0));
        en = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen |= ack;
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            seen |= ack;
        end
        chk("rst_no_ack", 256'(seen), 256'(1'b0));
        run_req("rd_line5", 32'h0000_00A0, PAT_JK, 1'b0, PAT_L5);

        // LATENCY=1 instance: ack on the edge after acceptance.
        addr = 32'h0000_0060; wr = 1'b0; en1 = 1'b1;
        tick();
        chk("lat1_accept_ack", 256'(ack1), 256'(1'b0));
        tick();
        chk("lat1_ack", 256'(ack1), 256'(1'b1));
        chk("lat1_data", dout1, PAT_A5);
        tick();
        chk("lat1_ack_drop", 256'(ack1), 256'(1'b0));
        en1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
